fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage. It owns the architectural PC and issues reads to instruction memory over a multi-cycle handshake.
- It presents one instruction at a time to decode, with a valid/stall handshake.
- It consumes the next-PC and branch/jump redirect produced by the execute stage, so it is the receiving end of execute's next-PC path.
- It sits between the top-level PC/redirect path and the decode stage.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- NOP_INSTR, 16'h0800, instruction word driven on instr whenever instr_valid=0.

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  synchronous active-high reset
- redirect  in  1  execute resolved taken branch/jump this cycle
- redirect_pc  in  16  target PC accompanying redirect
- halt  in  1  decode has seen HALT; qualified by handoff
- stall_in  in  1  decode not ready; hold current instruction
- mem_rd  out  1  instruction-memory read request
- mem_addr  out  16  read address
- mem_data  in  16  read data, valid with mem_done
- mem_done  in  1  read complete
- mem_stall  in  1  memory busy, request not accepted
- instr  out  16  fetched instruction
- instr_valid  out  1  instr/pc_out/pc_inc valid
- pc_out  out  16  PC of instr
- pc_inc  out  16  pc_out + 2
- err  out  1  misaligned fetch (see Optional Feature)

Behaviour:
- States: REQ, WAIT, HOLD, HALTED. All state, pc and output registers update on the rising edge of clk.
- Reset (rst=1, any state, including mid-request) has these effects:
  - state=REQ, pc=RESET_PC, kill=0.
  - instr=NOP_INSTR, instr_valid=0, pc_out=RESET_PC, pc_inc=RESET_PC+2, err=0.
  - mem_rd=0 during the reset cycle.
- REQ:
  - mem_rd=1 and mem_addr=pc, combinationally.
  - If mem_stall=1, stay in REQ and re-request the next cycle. Otherwise go to WAIT.
  - If redirect=1, mem_rd is suppressed, pc<=redirect_pc, and the state stays REQ.
- WAIT:
  - mem_rd=0. Wait any number of cycles for mem_done.
  - If redirect=1 in WAIT: pc<=redirect_pc, kill<=1.
  - On mem_done with kill=1 (or redirect in the same cycle): discard mem_data, clear kill, go to REQ.
  - On mem_done otherwise: instr<=mem_data, pc_out<=pc, pc_inc<=pc+2, go to HOLD.
- HOLD:
  - instr_valid=1. Outputs are stable while stall_in=1.
  - Handoff is stall_in=0; the handoff cycle is the last cycle instr_valid=1.
  - Priority at handoff: halt > redirect > sequential.
    - halt=1 -> HALTED.
    - redirect=1 -> pc<=redirect_pc, REQ.
    - otherwise -> pc<=pc+2, REQ.
  - A redirect while stall_in=1 still takes effect: the held instruction is dropped, pc<=redirect_pc, go to REQ.
- HALTED: mem_rd=0, instr_valid=0. redirect is ignored; only rst exits.
- Arithmetic:
  - PC math is modulo 2^16, so 16'hFFFE+2 = 16'h0000.
  - pc_inc uses the same rule.
- Latency:
  - Zero-wait memory (mem_done the cycle after the request): request at cycle N, instr_valid at N+2.
  - Peak throughput is one instruction per 3 cycles.
- instr=NOP_INSTR whenever instr_valid=0.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined: if pc[0]=1 on entry to REQ, no request is issued. The unit goes to HALTED with err=1, and err holds until rst.
- Not defined: err is tied 0 and mem_addr[0] is forced to 0.

Decomposition:
- Package fetch_pkg holds the state encoding (REQ, WAIT, HOLD, HALTED, 2-bit), the NOP constant 16'h0800, and the default RESET_PC.
- Sub-module: reuse the existing cla_16b adder for pc+2 (b=16'h0002, c_in=0). No other sub-modules.

Test Plan:
1. Reset, zero-wait memory, stall_in=0, mem returns 16'h1111 at 0x0000 and 16'h2222 at 0x0002 -> instr_valid at cycle 2 with instr=16'h1111, pc_out=0, pc_inc=2; next valid instr=16'h2222, pc_out=2.
2. mem_stall=1 for 3 cycles on the first REQ -> mem_rd held 4 cycles at mem_addr=0; no instr_valid until after acceptance.
3. Redirect to 16'h0040 while in WAIT -> returned data discarded, never valid; next mem_addr=16'h0040, next pc_out=16'h0040.
4. HOLD with stall_in=1 for 5 cycles -> instr/pc_out unchanged and no mem_rd; on release, next mem_addr=pc_out+2.
5. halt=1 and redirect=1 at handoff -> HALTED; mem_rd=0 and instr_valid=0 indefinitely; rst returns to fetch at RESET_PC.
6. redirect_pc=16'hFFFE, sequential -> next fetch address 16'h0000. With FETCH_ALIGN_CHK_EN, redirect_pc=16'h0013 -> err=1, no mem_rd.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and
// default constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [15:0] NOP_WORD         = 16'h0800;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
  localparam logic [15:0] PC_STEP          = 16'h0002;

endpackage

// File: rtl/fetch_unit_cla.sv
// 16-bit carry-lookahead adder (cla_16b): four 4-bit lookahead groups with
// group generate/propagate chained between groups.
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [4:0]  c_grp;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    c_grp = '0;
    c_grp[0] = c_in;
    for (int k = 0; k < 4; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
      c_grp[k+1] = grp_g[k] | (grp_p[k] & c_grp[k]);
      c[4*k] = c_grp[k];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
    end
    c[16] = c_grp[4];
  end

  assign sum   = p ^ c[15:0];
  assign c_out = c[16];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the multi-cycle memory handshake
// and hands one instruction at a time to decode. Optional FETCH_ALIGN_CHK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic        stall_in,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_done,
  input  logic        mem_stall,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc_out,
  output logic [15:0] pc_inc,
  output logic        err
);

  localparam logic [15:0] RESET_PC_INC = RESET_PC + PC_STEP;

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic [15:0]  instr_p1, pc_out_p1, pc_inc_p1;
  logic [15:0]  pc_plus2;
  logic         pc_add_cout_unused;
  logic         load_out;
  logic         rd_req;
  logic         misalign;
  logic         err_set;

  cla_16b u_pc_adder (
    .a     (pc_q),
    .b     (PC_STEP),
    .c_in  (1'b0),
    .sum   (pc_plus2),
    .c_out (pc_add_cout_unused)
  );

`ifdef FETCH_ALIGN_CHK_EN
  logic err_q;
  assign misalign = pc_q[0];
  assign mem_addr = pc_q;
  assign err      = err_q;
`else
  assign misalign = 1'b0;
  assign mem_addr = {pc_q[15:1], 1'b0};
  assign err      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    load_out = 1'b0;
    rd_req   = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      REQ: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (misalign) begin
          state_d = HALTED;
          err_set = 1'b1;
        end else begin
          rd_req = 1'b1;
          if (!mem_stall) state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) pc_d = redirect_pc;
        // A redirect arriving with mem_done kills that return just like kill_q.
        if (mem_done) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            load_out = 1'b1;
            state_d  = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (!stall_in) begin
          if (halt) begin
            state_d = HALTED;
          end else if (redirect) begin
            pc_d    = redirect_pc;
            state_d = REQ;
          end else begin
            pc_d    = pc_plus2;
            state_d = REQ;
          end
        end else if (redirect) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      instr_p1  <= NOP_INSTR;
      pc_out_p1 <= RESET_PC;
      pc_inc_p1 <= RESET_PC_INC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      // Memory return -> decode-facing output stage
      if (load_out) begin
        instr_p1  <= mem_data;
        pc_out_p1 <= pc_q;
        pc_inc_p1 <= pc_plus2;
      end
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
`endif

  assign mem_rd      = rd_req & ~rst;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_valid ? instr_p1 : NOP_INSTR;
  assign pc_out      = pc_out_p1;
  assign pc_inc      = pc_inc_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a simple zero-wait
// instruction-memory model driven from the stimulus thread.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, redirect, halt, stall_in;
  logic [15:0] redirect_pc;
  logic        mem_rd;
  logic [15:0] mem_addr, mem_data;
  logic        mem_done, mem_stall;
  logic [15:0] instr, pc_out, pc_inc;
  logic        instr_valid, err;
  logic        auto_mem;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .stall_in    (stall_in),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_done    (mem_done),
    .mem_stall   (mem_stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .pc_inc      (pc_inc),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memfn(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1111;
    if (a == 16'h0002) return 16'h2222;
    return 16'hA000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: captures an accepted request, then returns its data next cycle.
  task automatic tick();
    logic        acc;
    logic [15:0] a;
    #1;
    acc = mem_rd && !mem_stall && auto_mem;
    a   = mem_addr;
    @(posedge clk);
    #1;
    mem_done = acc;
    mem_data = acc ? memfn(a) : 16'h0000;
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
    stall_in = 1'b0; mem_data = 16'h0; mem_done = 1'b0; mem_stall = 1'b0;
    auto_mem = 1'b1;
    tick(); tick();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 16'h0800);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_pc_inc", pc_inc, 16'h0002);
    chk("rst_err", err, 0);

    // zero-wait sequential fetch
    rst = 1'b0;
    #1;
    chk("t1_rd", mem_rd, 1);
    chk("t1_addr", mem_addr, 16'h0000);
    tick();
    chk("t1_wait_valid", instr_valid, 0);
    tick();
    chk("t1_valid", instr_valid, 1);
    chk("t1_instr", instr, 16'h1111);
    chk("t1_pc_out", pc_out, 16'h0000);
    chk("t1_pc_inc", pc_inc, 16'h0002);
    tick();
    chk("t1_addr2", mem_addr, 16'h0002);
    tick(); tick();
    chk("t1_valid2", instr_valid, 1);
    chk("t1_instr2", instr, 16'h2222);
    chk("t1_pc_out2", pc_out, 16'h0002);
    chk("t1_pc_inc2", pc_inc, 16'h0004);
    tick(); tick(); tick();

    // decode stall holds the instruction
    chk("t4_instr", instr, 16'hA004);
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", instr_valid, 1);
      chk("t4_hold_instr", instr, 16'hA004);
      chk("t4_hold_pc", pc_out, 16'h0004);
      chk("t4_hold_rd", mem_rd, 0);
      tick();
    end
    stall_in = 1'b0;
    tick();
    chk("t4_next_rd", mem_rd, 1);
    chk("t4_next_addr", mem_addr, 16'h0006);

    // memory stall on the request
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_rd", mem_rd, 1);
      chk("t2_stall_addr", mem_addr, 16'h0006);
      chk("t2_stall_valid", instr_valid, 0);
      tick();
    end
    mem_stall = 1'b0;
    chk("t2_accept_rd", mem_rd, 1);
    chk("t2_accept_addr", mem_addr, 16'h0006);
    tick();
    chk("t2_wait_valid", instr_valid, 0);
    tick();
    chk("t2_instr", instr, 16'hA006);
    chk("t2_pc_out", pc_out, 16'h0006);

    // redirect while waiting on memory
    tick();
    chk("t3_addr", mem_addr, 16'h0008);
    auto_mem = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    #1;
    chk("t3_wait_rd", mem_rd, 0);
    tick();
    redirect = 1'b0;
    mem_done = 1'b1; mem_data = 16'hBAD0;
    #1;
    chk("t3_kill_valid", instr_valid, 0);
    tick();
    auto_mem = 1'b1;
    chk("t3_discard_valid", instr_valid, 0);
    chk("t3_discard_instr", instr, 16'h0800);
    chk("t3_rd", mem_rd, 1);
    chk("t3_new_addr", mem_addr, 16'h0040);
    tick(); tick();
    chk("t3_valid", instr_valid, 1);
    chk("t3_pc_out", pc_out, 16'h0040);
    chk("t3_instr", instr, 16'hA040);

    // halt beats redirect at handoff
    halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_halt_rd", mem_rd, 0);
      chk("t5_halt_valid", instr_valid, 0);
      chk("t5_halt_instr", instr, 16'h0800);
      tick();
    end
    redirect = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_restart_rd", mem_rd, 1);
    chk("t5_restart_addr", mem_addr, 16'h0000);

    // PC wrap at 16'hFFFE
    tick(); tick();
    chk("t6_instr", instr, 16'h1111);
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    #1;
    chk("t6_addr_fffe", mem_addr, 16'hFFFE);
    tick(); tick();
    chk("t6_pc_out", pc_out, 16'hFFFE);
    chk("t6_pc_inc", pc_inc, 16'h0000);
    chk("t6_instr_fffe", instr, 16'h5FFE);
    tick();
    chk("t6_wrap_addr", mem_addr, 16'h0000);
    chk("t6_wrap_rd", mem_rd, 1);

    // odd redirect target
    redirect = 1'b1; redirect_pc = 16'h0013;
    #1;
    chk("t6_redir_rd", mem_rd, 0);
    tick();
    redirect = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHK_EN
    chk("t6_odd_rd", mem_rd, 0);
    tick();
    chk("t6_err", err, 1);
    chk("t6_err_rd", mem_rd, 0);
    chk("t6_err_valid", instr_valid, 0);
    tick();
    chk("t6_err_hold", err, 1);
`else
    chk("t6_odd_rd", mem_rd, 1);
    chk("t6_odd_addr", mem_addr, 16'h0012);
    chk("t6_err", err, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
